// File: rtl/serial_alu_sequencer_pkg.sv
// Shared encodings for the bit-serial ALU: control words, slice op codes,
// sequencer states and the signed less-than helper.
package serial_alu_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_SUM  = 2'b10,
    OP_LESS = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    ainvert;
    logic    binvert;
    alu_op_e op;
  } alu_ctl_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_FINISH = 2'b10;

  // Sign of (a - b) corrected for overflow: sum_msb XOR overflow.
  function automatic logic slt_set(input logic sum_msb, input logic c_in_msb,
                                   input logic c_out);
    return sum_msb ^ (c_in_msb ^ c_out);
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Operand/result bus between the operand stage (master) and the serial ALU (slave).
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             done;

  modport master (
    output start, a_in, b_in, alu_ctl,
    input  ready, result, zero, cout, overflow, done
  );

  modport slave (
    input  start, a_in, b_in, alu_ctl,
    output ready, result, zero, cout, overflow, done
  );
endinterface

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: AND / OR / full-add of optionally inverted inputs.
module serial_alu_slice
  import serial_alu_sequencer_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    ainvert,
  input  logic    binvert,
  input  alu_op_e op,
  input  logic    cin,
  output logic    result,
  output logic    sum,
  output logic    cout
);

  logic a_eff_s;
  logic b_eff_s;

  // Bit function; the less-than path has no per-bit value here, the sequencer forms it.
  always_comb begin
    a_eff_s = a ^ ainvert;
    b_eff_s = b ^ binvert;
    sum     = a_eff_s ^ b_eff_s ^ cin;
    cout    = (a_eff_s & b_eff_s) | (a_eff_s & cin) | (b_eff_s & cin);
    case (op)
      OP_AND:  result = a_eff_s & b_eff_s;
      OP_OR:   result = a_eff_s | b_eff_s;
      OP_SUM:  result = sum;
      OP_LESS: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial N-bit ALU: feeds one slice LSB first, holding the carry between
// cycles, and publishes result/flags with a one-cycle done pulse.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset,
  serial_alu_sequencer_if.slave bus
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]       state_r;
  alu_ctl_t         ctl_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             c_in_msb_r;
  logic             sum_msb_r;
  logic             ready_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             cout_r;
  logic             ovf_r;

  logic             slice_res_s;
  logic             slice_sum_s;
  logic             slice_cout_s;
  logic             bit_s;
  logic             arith_s;
  logic             set_s;
  logic [WIDTH-1:0] final_s;

  serial_alu_slice u_slice (
    .a       (a_r[0]),
    .b       (b_r[0]),
    .ainvert (ctl_r.ainvert),
    .binvert (ctl_r.binvert),
    .op      (ctl_r.op),
    .cin     (carry_r),
    .result  (slice_res_s),
    .sum     (slice_sum_s),
    .cout    (slice_cout_s)
  );

  // Bit to shift in, and the final result/flag terms used in FINISH.
  always_comb begin
    arith_s = (ctl_r.op == OP_SUM) || (ctl_r.op == OP_LESS);
    set_s   = slt_set(sum_msb_r, c_in_msb_r, carry_r);
    if (ctl_r.op == OP_LESS) begin
      bit_s   = slice_sum_s;
      final_s = {{(WIDTH-1){1'b0}}, set_s};
    end else begin
      bit_s   = slice_res_s;
      final_s = shreg_r;
    end
  end

  // Sequencer FSM, operand shifters, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ctl_r      <= alu_ctl_t'(4'b0000);
      a_r        <= '0;
      b_r        <= '0;
      shreg_r    <= '0;
      cnt_r      <= '0;
      carry_r    <= 1'b0;
      c_in_msb_r <= 1'b0;
      sum_msb_r  <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      result_r   <= '0;
      zero_r     <= 1'b0;
      cout_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a_in;
            b_r     <= bus.b_in;
            ctl_r   <= alu_ctl_t'(bus.alu_ctl);
            carry_r <= bus.alu_ctl[2];
            cnt_r   <= '0;
            ready_r <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Operands shift right so the slice always sees bit cnt_r at position 0.
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          shreg_r <= {bit_s, shreg_r[WIDTH-1:1]};
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            c_in_msb_r <= carry_r;
            sum_msb_r  <= slice_sum_s;
            state_r    <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          result_r <= final_s;
          zero_r   <= (final_s == '0);
          cout_r   <= arith_s ? carry_r : 1'b0;
          ovf_r    <= arith_s ? (c_in_msb_r ^ carry_r) : 1'b0;
          done_r   <= 1'b1;
          ready_r  <= 1'b1;
          state_r  <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = ready_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.zero     = zero_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer at WIDTH=8: expected results are
// queued at each accepted start and compared when done pulses.
module tb_serial_alu_sequencer;
  import serial_alu_sequencer_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] ctl, input int done_cyc);
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    logic [W:0]   s;
    exp_t         e;
    aa     = ctl[3] ? ~a : a;
    bb     = ctl[2] ? ~b : b;
    s      = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[2]};
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (ctl[1:0])
      2'b00:   e.result = aa & bb;
      2'b01:   e.result = aa | bb;
      default: begin
        e.cout = s[W];
        e.ovf  = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
        if (ctl[1:0] == 2'b11) e.result = {{(W-1){1'b0}}, s[W-1] ^ e.ovf};
        else                   e.result = s[W-1:0];
      end
    endcase
    e.zero = (e.result == '0);
    e.cyc  = done_cyc;
    return e;
  endfunction

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("result", 64'(bus.result), 64'(e.result));
        check("zero", 64'(bus.zero), 64'(e.zero));
        check("cout", 64'(bus.cout), 64'(e.cout));
        check("overflow", 64'(bus.overflow), 64'(e.ovf));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!bus.ready) begin
      n++;
      if (n > 50) begin
        check("ready_timeout", 64'd0, 64'd1);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] ctl, output int acc);
    bus.start   = 1'b1;
    bus.a_in    = a;
    bus.b_in    = b;
    bus.alu_ctl = ctl;
    @(posedge clk);
    #1;
    acc         = cyc;
    bus.start   = 1'b0;
    bus.a_in    = W'($urandom);
    bus.b_in    = W'($urandom);
    bus.alu_ctl = 4'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl);
    bit ok;
    int acc;
    wait_ready(ok);
    if (ok) begin
      start_op(a, b, ctl, acc);
      sb_q.push_back(model(a, b, ctl, acc + W + 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int acc_prev;
    bit ok;
    bus.start   = 1'b0;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.alu_ctl = 4'b0000;

    @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_op(8'hF0, 8'h3C, ALU_AND);
    drain();

    // Reset in the middle of an ADD: aborted, no done, outputs back to reset values.
    wait_ready(ok);
    if (ok) start_op(8'h12, 8'h34, ALU_ADD, acc);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_zero", 64'(bus.zero), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (12) @(negedge clk);

    run_op(8'h7F, 8'h01, ALU_ADD);
    run_op(8'h05, 8'h05, ALU_SUB);
    run_op(8'h80, 8'h01, ALU_SLT);
    run_op(8'h01, 8'h80, ALU_SLT);
    run_op(8'h7F, 8'h80, ALU_SLT);
    run_op(8'hF0, 8'h3C, ALU_OR);
    run_op(8'hF0, 8'h3C, ALU_NOR);
    run_op(8'hC8, 8'h64, ALU_ADD);
    run_op(8'h03, 8'h09, ALU_SUB);
    drain();

    // Start pulsed during RUN must be ignored.
    wait_ready(ok);
    if (ok) begin
      start_op(8'h11, 8'h22, ALU_ADD, acc);
      sb_q.push_back(model(8'h11, 8'h22, ALU_ADD, acc + W + 1));
    end
    repeat (3) @(negedge clk);
    bus.start   = 1'b1;
    bus.a_in    = 8'hFF;
    bus.b_in    = 8'hFF;
    bus.alu_ctl = ALU_SUB;
    @(negedge clk);
    bus.start   = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    wait_ready(ok);
    acc_prev = 0;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'(8'h10 + 8'(k * 37));
      b = W'(8'h05 + 8'(k * 11));
      bus.a_in    = a;
      bus.b_in    = b;
      bus.alu_ctl = ALU_ADD;
      n = 0;
      while (!bus.ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready_wait", 64'(bus.ready), 64'd1);
      @(posedge clk);
      #1;
      acc = cyc;
      sb_q.push_back(model(a, b, ALU_ADD, acc + W + 1));
      if (k > 0) check("b2b_gap", 64'(acc - acc_prev), 64'(W + 2));
      acc_prev = acc;
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
